// File: rtl/apb_master_nslave.sv
// APB3 bridge from the core data-bus handshake to NUM_SLAVES completers.
// Address-decoded PSEL, error response for unmapped addresses, optional PREADY timeout.
//
// state  | meaning
// IDLE   | bus idle, decoding addr while waiting for transfer
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waiting for PREADY or timeout
// ERR    | one-cycle error completion for an unmapped address
module apb_master_nslave #(
  parameter int          NUM_SLAVES    = 6,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter int          SLV_ADDR_BITS = 12,
  parameter int          TIMEOUT       = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [31:0]           off;
  logic [31:0]           idx;
  logic                  hit;
  logic                  pready_sel;
  logic [31:0]           prdata_sel;
  logic [NUM_SLAVES-1:0] sel_onehot;

  // Unsigned compares: an address below BASE_ADDR wraps to a huge offset, never a hit.
  always_comb begin
    off = addr - BASE_ADDR;
    idx = off >> SLV_ADDR_BITS;
    hit = (addr >= BASE_ADDR) && (idx < 32'(NUM_SLAVES));
  end

  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_onehot[i] = 1'b1;
        pready_sel    = PREADY[i];
        prdata_sel    = PRDATA[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    PSEL     = '0;
    PENABLE  = 1'b0;
    ready    = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          if (hit) begin
            paddr_d  = addr;
            pwdata_d = wdata;
            pwrite_d = write;
            sel_d    = idx[SEL_W-1:0];
            state_d  = S_SETUP;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SETUP: begin
        PSEL    = sel_onehot;
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        PSEL    = sel_onehot;
        PENABLE = 1'b1;
        // PREADY wins over a timeout landing on the same cycle.
        if (pready_sel) begin
          ready   = 1'b1;
          rdata   = prdata_sel;
          state_d = S_IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ERR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PADDR  = paddr_q;
  assign PWDATA = pwdata_q;
  assign PWRITE = pwrite_q;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Bench for apb_master_nslave: transaction-level model checked every cycle on the
// main instance, directed literal cases, and decode sweeps on two other configurations.
module tb_apb_master_nslave;

  localparam int          NS   = 6;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int          SAB  = 12;
  localparam int          TO   = 16;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;

  logic          transfer = 1'b0, write = 1'b0;
  logic [31:0]   addr = '0, wdata = '0;
  logic [31:0]   rdata, PADDR, PWDATA;
  logic          ready, err, PWRITE, PENABLE;
  logic [NS-1:0] PSEL;
  logic [32*NS-1:0] PRDATA = '0;
  logic [NS-1:0] PREADY = '0;

  logic          b_transfer = 1'b0, b_write = 1'b0;
  logic [31:0]   b_addr = '0, b_wdata = '0;
  logic [31:0]   b_rdata, b_paddr, b_pwdata;
  logic          b_ready, b_err, b_pwrite, b_penable;
  logic [15:0]   b_psel;
  logic [511:0]  b_prdata = '0;
  logic [15:0]   b_pready = '0;

  logic [31:0]   c_rdata, c_paddr, c_pwdata;
  logic          c_ready, c_err, c_pwrite, c_penable;
  logic [0:0]    c_psel;
  logic [31:0]   c_prdata = '0;
  logic [0:0]    c_pready = '0;

  int checks = 0;
  int errors = 0;

  apb_master_nslave #(.NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLV_ADDR_BITS(SAB), .TIMEOUT(TO)) u_dut_a (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY));

  apb_master_nslave #(.NUM_SLAVES(16), .BASE_ADDR(BASE), .SLV_ADDR_BITS(8), .TIMEOUT(0)) u_dut_b (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(b_transfer), .write(b_write), .addr(b_addr), .wdata(b_wdata),
    .rdata(b_rdata), .ready(b_ready), .err(b_err), .PADDR(b_paddr), .PWDATA(b_pwdata), .PWRITE(b_pwrite),
    .PENABLE(b_penable), .PSEL(b_psel), .PRDATA(b_prdata), .PREADY(b_pready));

  apb_master_nslave #(.NUM_SLAVES(1), .BASE_ADDR(BASE), .SLV_ADDR_BITS(8), .TIMEOUT(4)) u_dut_c (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(b_transfer), .write(b_write), .addr(b_addr), .wdata(b_wdata),
    .rdata(c_rdata), .ready(c_ready), .err(c_err), .PADDR(c_paddr), .PWDATA(c_pwdata), .PWRITE(c_pwrite),
    .PENABLE(c_penable), .PSEL(c_psel), .PRDATA(c_prdata), .PREADY(c_pready));

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Region index of an address, or -1 when unmapped.
  function automatic int decode(input logic [31:0] a, input int nsl, input int bits);
    longint unsigned region;
    if (a < BASE) return -1;
    region = (64'(a) - 64'(BASE)) / (64'd1 << bits);
    return (region < longint'(nsl)) ? int'(region) : -1;
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
    for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) b_prdata[32*i +: 32] = $urandom;
    c_prdata = $urandom;
  endtask

  // Transaction model of instance A: one outstanding request, its age in cycles
  // since acceptance (1 = setup), and the target region or -1 for unmapped.
  int          m_busy = 0, m_tgt = 0, m_age = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_write = 1'b0;

  always @(negedge PCLK) begin : cmp
    logic [NS-1:0] e_psel;
    logic          e_pen, e_rdy, e_err, done;
    logic [31:0]   e_rdata;
    e_psel = '0; e_pen = 1'b0; e_rdy = 1'b0; e_err = 1'b0; e_rdata = '0; done = 1'b0;
    if (PRESET) begin
      m_busy = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_write = 1'b0;
    end else if (m_busy != 0) begin
      if (m_tgt < 0) begin
        e_rdy = 1'b1; e_err = 1'b1; done = 1'b1;
      end else begin
        e_psel = NS'(1) << m_tgt;
        if (m_age >= 2) begin
          e_pen = 1'b1;
          if (PREADY[m_tgt]) begin
            e_rdy = 1'b1; e_rdata = PRDATA[32*m_tgt +: 32]; done = 1'b1;
          end else if (TO != 0 && (m_age - 2) == TO - 1) begin
            e_rdy = 1'b1; e_err = 1'b1; done = 1'b1;
          end
        end
      end
    end
    chk("m_psel", 32'(PSEL), 32'(e_psel));
    chk("m_penable", 32'(PENABLE), 32'(e_pen));
    chk("m_ready", 32'(ready), 32'(e_rdy));
    chk("m_err", 32'(err), 32'(e_err));
    chk("m_rdata", rdata, e_rdata);
    chk("m_paddr", PADDR, m_addr);
    chk("m_pwdata", PWDATA, m_wdata);
    chk("m_pwrite", 32'(PWRITE), 32'(m_write));
    if (!PRESET) begin
      if (m_busy != 0) begin
        if (done) m_busy = 0;
        else m_age++;
      end else if (transfer) begin
        m_tgt = decode(addr, NS, SAB);
        if (m_tgt >= 0) begin
          m_addr = addr; m_wdata = wdata; m_write = write;
        end
        m_busy = 1;
        m_age  = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] um [2];
  logic [31:0] sa;
  int eb, ec;

  initial begin
    um[0] = 32'h1000_6000;
    um[1] = 32'h0FFF_FFFC;
    repeat (3) step();
    @(negedge PCLK);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    #1 PRESET = 1'b0;

    // Write to slave 1, PREADY in the first access cycle.
    step(); transfer = 1'b1; write = 1'b1; addr = 32'h1000_1004; wdata = 32'hA5A5_0001; PREADY = '0;
    @(negedge PCLK); chk("t1_c0_psel", 32'(PSEL), 32'h0);
    step(); transfer = 1'b0; write = 1'b0; addr = $urandom; wdata = $urandom;
    @(negedge PCLK);
    chk("t1_c1_psel", 32'(PSEL), 32'h2);
    chk("t1_c1_penable", 32'(PENABLE), 32'h0);
    chk("t1_c1_paddr", PADDR, 32'h1000_1004);
    chk("t1_c1_pwdata", PWDATA, 32'hA5A5_0001);
    chk("t1_c1_ready", 32'(ready), 32'h0);
    step(); PREADY = 6'b000010;
    @(negedge PCLK);
    chk("t1_c2_psel", 32'(PSEL), 32'h2);
    chk("t1_c2_penable", 32'(PENABLE), 32'h1);
    chk("t1_c2_ready", 32'(ready), 32'h1);
    chk("t1_c2_err", 32'(err), 32'h0);
    chk("t1_c2_pwrite", 32'(PWRITE), 32'h1);
    step(); PREADY = '0;
    @(negedge PCLK);
    chk("t1_c3_psel", 32'(PSEL), 32'h0);
    chk("t1_c3_ready", 32'(ready), 32'h0);

    // Read from slave 5 with three wait cycles; other slaves assert PREADY meanwhile.
    step(); transfer = 1'b1; write = 1'b0; addr = 32'h1000_5008; PRDATA[160 +: 32] = 32'h1234_5678;
    step(); transfer = 1'b0; PRDATA[160 +: 32] = 32'h1234_5678;
    for (int c = 2; c <= 5; c++) begin
      step(); PRDATA[160 +: 32] = 32'h1234_5678;
      PREADY = (c == 5) ? 6'b100000 : 6'b011111;
      @(negedge PCLK);
      chk("t2_psel", 32'(PSEL), 32'h20);
      chk("t2_ready", 32'(ready), (c == 5) ? 32'h1 : 32'h0);
      chk("t2_rdata", rdata, (c == 5) ? 32'h1234_5678 : 32'h0);
    end
    step(); PREADY = '0;

    // Unmapped addresses complete with an error in the cycle after the request.
    for (int k = 0; k < 2; k++) begin
      step(); transfer = 1'b1; addr = um[k];
      step(); transfer = 1'b0;
      @(negedge PCLK);
      chk("t3_psel", 32'(PSEL), 32'h0);
      chk("t3_penable", 32'(PENABLE), 32'h0);
      chk("t3_ready", 32'(ready), 32'h1);
      chk("t3_err", 32'(err), 32'h1);
      chk("t3_rdata", rdata, 32'h0);
      step();
      @(negedge PCLK); chk("t3_after_ready", 32'(ready), 32'h0);
    end

    // Slave 0 never answers: error completion in access cycle 16 (cycle 17).
    step(); transfer = 1'b1; write = 1'b1; addr = 32'h1000_0010; PREADY = '0;
    step(); transfer = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      step();
      @(negedge PCLK);
      chk("t4_ready", 32'(ready), (c == 17) ? 32'h1 : 32'h0);
      chk("t4_err", 32'(err), (c == 17) ? 32'h1 : 32'h0);
    end
    step();
    @(negedge PCLK);
    chk("t4_idle_psel", 32'(PSEL), 32'h0);
    chk("t4_idle_ready", 32'(ready), 32'h0);
    step(); transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
    step(); transfer = 1'b0;
    step(); PREADY = 6'b000100;
    @(negedge PCLK);
    chk("t4_next_ready", 32'(ready), 32'h1);
    chk("t4_next_err", 32'(err), 32'h0);
    chk("t4_next_rdata", rdata, PRDATA[64 +: 32]);
    step(); PREADY = '0;

    // Reset in the middle of a slave-3 access.
    step(); transfer = 1'b1; addr = 32'h1000_3000;
    step(); transfer = 1'b0;
    step(); step();
    @(negedge PCLK);
    chk("t5_pre_penable", 32'(PENABLE), 32'h1);
    #1 PRESET = 1'b1;
    #1;
    chk("t5_async_psel", 32'(PSEL), 32'h0);
    chk("t5_async_penable", 32'(PENABLE), 32'h0);
    chk("t5_async_ready", 32'(ready), 32'h0);
    PREADY = 6'b001000;
    step(); step();
    @(negedge PCLK);
    #1 PRESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(); PREADY = 6'b001000;
      @(negedge PCLK); chk("t5_no_ready", 32'(ready), 32'h0);
    end
    step(); transfer = 1'b1; addr = 32'h1000_3000;
    step(); transfer = 1'b0;
    step();
    @(negedge PCLK);
    chk("t5_next_ready", 32'(ready), 32'h1);
    chk("t5_next_err", 32'(err), 32'h0);
    step(); PREADY = '0;

    // Random traffic on instance A; pulses while busy must be dropped.
    repeat (400) begin
      step();
      transfer = ($urandom % 3) == 0;
      write = $urandom;
      wdata = $urandom;
      PREADY = NS'($urandom);
      case ($urandom % 4)
        0, 1: addr = BASE + (($urandom % NS) << SAB) + ($urandom % 4096);
        2:    addr = BASE + ((NS + ($urandom % 2)) << SAB) + ($urandom % 4096);
        default: addr = ($urandom % 2) ? $urandom : BASE - 32'd1 - ($urandom % 16);
      endcase
    end
    step(); transfer = 1'b0; PREADY = '0;
    repeat (20) step();

    // Instance B has no timeout: it waits as long as PREADY stays low.
    step(); b_transfer = 1'b1; b_write = 1'b1; b_addr = 32'h1000_0900; b_wdata = 32'hCAFE_0009;
    step(); b_transfer = 1'b0;
    for (int c = 2; c <= 41; c++) begin
      step();
      @(negedge PCLK);
      chk("b_wait_ready", 32'(b_ready), 32'h0);
      chk("b_wait_psel", 32'(b_psel), 32'h200);
    end
    step(); b_pready = 16'h0200;
    @(negedge PCLK);
    chk("b_wait_done", 32'(b_ready), 32'h1);
    chk("b_wait_err", 32'(b_err), 32'h0);
    chk("b_wait_pwdata", b_pwdata, 32'hCAFE_0009);
    step(); b_pready = '0;

    // Decode sweep on instances B (16 x 256 B) and C (1 x 256 B).
    b_pready = '1; c_pready = 1'b1;
    repeat (40) begin
      step();
      b_transfer = 1'b1; b_write = $urandom; b_wdata = $urandom;
      if (($urandom % 4) == 0) b_addr = BASE - 32'd1 - ($urandom % 300);
      else b_addr = BASE + (($urandom % 20) << 8) + ($urandom % 256);
      sa = b_addr;
      eb = decode(sa, 16, 8);
      ec = decode(sa, 1, 8);
      step(); b_addr = $urandom;
      @(negedge PCLK);
      chk("b_c1_psel", 32'(b_psel), (eb >= 0) ? (32'h1 << eb) : 32'h0);
      chk("b_c1_ready", 32'(b_ready), (eb < 0) ? 32'h1 : 32'h0);
      chk("b_c1_err", 32'(b_err), (eb < 0) ? 32'h1 : 32'h0);
      chk("c_c1_psel", 32'(c_psel), (ec >= 0) ? 32'h1 : 32'h0);
      chk("c_c1_err", 32'(c_err), (ec < 0) ? 32'h1 : 32'h0);
      step(); b_transfer = 1'b0;
      @(negedge PCLK);
      chk("b_c2_ready", 32'(b_ready), (eb >= 0) ? 32'h1 : 32'h0);
      chk("b_c2_err", 32'(b_err), 32'h0);
      if (eb >= 0) begin
        chk("b_c2_rdata", b_rdata, b_prdata[32*eb +: 32]);
        chk("b_c2_paddr", b_paddr, sa);
      end else begin
        chk("b_c2_rdata", b_rdata, 32'h0);
      end
      chk("c_c2_ready", 32'(c_ready), (ec >= 0) ? 32'h1 : 32'h0);
      chk("c_c2_rdata", c_rdata, (ec >= 0) ? c_prdata : 32'h0);
      if (ec >= 0) chk("c_c2_paddr", c_paddr, sa);
      chk("c_c2_penable", 32'(c_penable), (ec >= 0) ? 32'h1 : 32'h0);
      chk("c_c2_pwrite", 32'(c_pwrite), (ec >= 0) ? 32'(b_pwrite) : 32'(c_pwrite));
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
